// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
package bram_arb_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

    localparam int REQ_CPU  = 0;
    localparam int REQ_DBG  = 1;
    localparam int STARVE_W = 8;

endpackage

// File: rtl/bram_starve_counter.sv
// Starvation guard for requester 1: counts denied cycles and raises force_r1
// for the cycle after the count reaches STARVE_LIMIT.
module bram_starve_counter
    import bram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic r1_req,
    input  logic r1_gnt,
    output logic force_r1
);

    localparam logic [STARVE_W:0] LIMIT = STARVE_LIMIT[STARVE_W:0];
    localparam logic [STARVE_W:0] ONE   = {{STARVE_W{1'b0}}, 1'b1};

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STARVE_W-1:0] count;
    logic [STARVE_W-1:0] count_next;
    logic [STARVE_W:0]   count_inc;
    logic                denied;

    assign denied    = r1_req & ~r1_gnt;
    assign count_inc = {1'b0, count} + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_NORMAL;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The extra bit on count_inc keeps the limit compare exact at the 255 saturation point.
    always_comb begin
        state_next = state;
        count_next = count;
        if (!denied)
            count_next = '0;
        else if (count != '1)
            count_next = count_inc[STARVE_W-1:0];

        case (state)
            ST_NORMAL: if (denied && count_inc == LIMIT) state_next = ST_FORCE;
            ST_FORCE:  if (!denied) state_next = ST_NORMAL;
            default:   state_next = ST_NORMAL;
        endcase
    end

    assign force_r1 = (state == ST_FORCE);

endmodule

// File: rtl/bram_arbiter.sv
// Fixed-priority arbiter sharing one single-port BRAM between the MEM stage
// (requester 0) and the debug/loader (requester 1), with a starvation guard.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    r0_req,
    input  logic                    r0_we,
    input  logic [ADDRESS_BITS-1:0] r0_addr,
    input  logic [DATA_BITS-1:0]    r0_wdata,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    input  logic                    r1_req,
    input  logic                    r1_we,
    input  logic [ADDRESS_BITS-1:0] r1_addr,
    input  logic [DATA_BITS-1:0]    r1_wdata,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [DATA_BITS-1:0]    rdata,
    output logic                    bram_we,
    output logic [ADDRESS_BITS-1:0] bram_addr,
    output logic [DATA_BITS-1:0]    bram_wdata,
    input  logic [DATA_BITS-1:0]    bram_rdata
);

    logic       force_r1;
    logic [1:0] gnt;

    bram_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .r1_req  (r1_req),
        .r1_gnt  (gnt[REQ_DBG]),
        .force_r1(force_r1)
    );

    // Grants are gated by rst so nothing reaches the BRAM while reset is held.
    always_comb begin
        gnt        = '0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (!rst) begin
            if (r1_req && (force_r1 || !r0_req))
                gnt[REQ_DBG] = 1'b1;
            else if (r0_req)
                gnt[REQ_CPU] = 1'b1;
        end
        if (gnt[REQ_CPU]) begin
            bram_we    = r0_we;
            bram_addr  = r0_addr;
            bram_wdata = r0_wdata;
        end else if (gnt[REQ_DBG]) begin
            bram_we    = r1_we;
            bram_addr  = r1_addr;
            bram_wdata = r1_wdata;
        end
    end

    assign r0_gnt = gnt[REQ_CPU];
    assign r1_gnt = gnt[REQ_DBG];
    assign rdata  = bram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= gnt[REQ_CPU] & ~r0_we;
            r1_rvalid <= gnt[REQ_DBG] & ~r1_we;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural single-port BRAM.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [7:0]  r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [7:0]  r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, bram_we;
    logic [31:0] rdata, bram_wdata;
    logic [31:0] bram_rdata = '0;
    logic [7:0]  bram_addr;

    logic [31:0] mem [0:255];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int vectors = 0;
    int miscompares = 0;

    bram_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rdata(rdata), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port BRAM: o_data is registered on read edges and held during writes.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        else         bram_rdata     <= mem[bram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(
        input string tag,
        input logic q0r, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
        input logic q1r, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic [31:0] erd);
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        @(negedge clk);
        r0_req = q0r; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1r; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        #1;
        exp_we    = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        exp_addr  = eg0 ? a0 : (eg1 ? a1 : 8'h00);
        exp_wdata = eg0 ? d0 : (eg1 ? d1 : 32'h0);
        checkOutput({tag, "_r0_gnt"}, 32'(r0_gnt), 32'(eg0));
        checkOutput({tag, "_r1_gnt"}, 32'(r1_gnt), 32'(eg1));
        checkOutput({tag, "_bram_we"}, 32'(bram_we), 32'(exp_we));
        checkOutput({tag, "_bram_addr"}, 32'(bram_addr), 32'(exp_addr));
        checkOutput({tag, "_bram_wdata"}, bram_wdata, exp_wdata);
        if (eg0 && !w0) q0.push_back(erd);
        if (eg1 && !w1) q1.push_back(erd);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0);
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding read of that requester.
    initial begin
        forever begin
            @(negedge clk);
            if (r0_rvalid) begin
                if (q0.size() == 0) checkOutput("r0_rvalid_unexpected", 32'd1, 32'd0);
                else checkOutput("r0_rdata", rdata, q0.pop_front());
            end
            if (r1_rvalid) begin
                if (q1.size() == 0) checkOutput("r1_rvalid_unexpected", 32'd1, 32'd0);
                else checkOutput("r1_rdata", rdata, q1.pop_front());
            end
        end
    end

    initial begin
        // Grants must stay low while reset is held, even with requests pending.
        r0_req = 1'b1; r1_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        checkOutput("rst_r1_gnt", 32'(r1_gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;

        // Reset mid-read: the granted read must never produce rvalid.
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
        #1;
        checkOutput("midrst_r0_gnt", 32'(r0_gnt), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_gnt_forced", 32'(r0_gnt), 32'd0);
        checkOutput("midrst_we_forced", 32'(bram_we), 32'd0);
        @(negedge clk);
        checkOutput("midrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        r0_req = 1'b0; r0_addr = 8'h00;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_r0_gnt", 32'(r0_gnt), 32'd0);
        checkOutput("post_rst_r1_gnt", 32'(r1_gnt), 32'd0);
        checkOutput("post_rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        checkOutput("post_rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        checkOutput("post_rst_bram_we", 32'(bram_we), 32'd0);
        checkOutput("post_rst_bram_addr", 32'(bram_addr), 32'd0);
        checkOutput("post_rst_state", 32'(dut.u_starve.state), 32'd0);
        checkOutput("post_rst_count", 32'(dut.u_starve.count), 32'd0);

        // Requester 0 alone: write then read back.
        applyStimulus("r0_wr05", 1, 1, 8'h05, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        applyStimulus("r0_rd05", 1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'hDEADBEEF);
        idle("idle_a");

        // Preload through requester 0 for the later read tests.
        applyStimulus("pre_20", 1, 1, 8'h20, 32'h12345678, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        applyStimulus("pre_01", 1, 1, 8'h01, 32'h11111111, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        applyStimulus("pre_02", 1, 1, 8'h02, 32'h22222222, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        applyStimulus("pre_03", 1, 1, 8'h03, 32'h33333333, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        idle("idle_b");

        // Requester 1 alone.
        applyStimulus("r1_rd20", 0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 32'h12345678);
        idle("idle_c");
        idle("idle_d");

        // Continuous contention: r1 forced in cycles 4 and 9.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("cont%0d", i),
                          1, 1, 8'h40, 32'hA0A0A0A0, 1, 1, 8'h50, 32'hB1B1B1B1,
                          (i != 4 && i != 9), (i == 4 || i == 9), 32'h0);
            checkOutput($sformatf("cont%0d_onehot", i), 32'(r0_gnt & r1_gnt), 32'd0);
        end
        idle("idle_e");

        // Reach ST_FORCE, then abandon it by dropping r1_req.
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("abn%0d", i),
                          1, 1, 8'h41, 32'hC0C0C0C0, 1, 1, 8'h51, 32'hD1D1D1D1, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("abn_state_force", 32'(dut.u_starve.state), 32'd1);
        checkOutput("abn_count", 32'(dut.u_starve.count), 32'd4);
        applyStimulus("abn_drop", 1, 1, 8'h42, 32'hC1C1C1C1, 0, 1, 8'h51, 32'hD1D1D1D1, 1, 0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("abn_state_normal", 32'(dut.u_starve.state), 32'd0);
        checkOutput("abn_count_clear", 32'(dut.u_starve.count), 32'd0);

        // Pipelined reads followed by a write.
        applyStimulus("pipe_rd01", 1, 0, 8'h01, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'h11111111);
        applyStimulus("pipe_rd02", 1, 0, 8'h02, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'h22222222);
        applyStimulus("pipe_rd03", 1, 0, 8'h03, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'h33333333);
        applyStimulus("pipe_wr04", 1, 1, 8'h04, 32'h44444444, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0);
        checkOutput("pipe_rvalid_in_write", 32'(r0_rvalid), 32'd1);
        idle("idle_f");
        idle("idle_g");
        @(negedge clk);
        #1;
        checkOutput("q0_drained", 32'(q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port BRAM between two requesters:
  - Requester 0 is the pipeline MEM stage. It has priority.
  - Requester 1 is the debug/loader unit.
- Uses fixed priority to requester 0, plus a starvation guard that forces a grant to requester 1 after STARVE_LIMIT denied cycles.
- Sits between the two requesters and the BRAM instance. It owns every BRAM input port and routes the BRAM read data back with a per-requester valid.

Parameters:
- ADDRESS_BITS, 8, BRAM address width.
- DATA_BITS, 32, BRAM data width.
- STARVE_LIMIT, 4, consecutive denied cycles of r1_req before requester 1 is forced. Legal range is 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  requester 0 write (1) / read (0).
- r0_addr  in  ADDRESS_BITS  requester 0 address.
- r0_wdata  in  DATA_BITS  requester 0 write data.
- r0_gnt  out  1  requester 0 access accepted this cycle.
- r0_rvalid  out  1  rdata holds requester 0 read result.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid: same as requester 0, for requester 1.
- rdata  out  DATA_BITS  shared read data, equal to bram_rdata.
- bram_we  out  1  to BRAM write_enable.
- bram_addr  out  ADDRESS_BITS  to BRAM i_address.
- bram_wdata  out  DATA_BITS  to BRAM i_data.
- bram_rdata  in  DATA_BITS  from BRAM o_data.

Behaviour:
- Reset:
  - State goes to ST_NORMAL; starvation counter goes to 0.
  - r0_rvalid and r1_rvalid go to 0.
  - While rst is high, r0_gnt, r1_gnt and bram_we are forced to 0.
  - A read granted before reset produces no rvalid.
- Grant is combinational from the current registered state and the req inputs. A requester samples gnt in the same cycle it holds req. Requesters must hold req, we, addr and wdata stable until gnt.
- ST_NORMAL:
  - r0_req=1 grants requester 0.
  - Otherwise r1_req=1 grants requester 1.
  - Otherwise no grant.
- ST_FORCE:
  - r1_req=1 grants requester 1, even if r0_req=1.
  - If r1_req has dropped, falls back to the ST_NORMAL rule.
- At most one gnt is high per cycle.
- BRAM drive:
  - The granted requester's we/addr/wdata drive bram_we/bram_addr/bram_wdata.
  - With no grant: bram_we=0, bram_addr=0, bram_wdata=0.
- Starvation counter (8 bit):
  - Cleared when r1_gnt=1 or r1_req=0.
  - Otherwise, when r1_req=1 and not granted, increments, saturating at 255.
- State transitions:
  - ST_NORMAL to ST_FORCE at the clock edge where the counter would reach STARVE_LIMIT.
  - ST_FORCE to ST_NORMAL on any edge where r1_gnt=1 or r1_req=0.
- Read latency is 1 cycle:
  - Next-cycle rX_rvalid = rX_gnt & ~rX_we, registered.
  - rvalid is a single-cycle pulse per granted read.
  - rdata = bram_rdata combinationally; it is meaningful only while an rvalid is high.
- Writes produce no rvalid. The BRAM holds o_data during a write, so rdata is stale during and after writes.
- Back-to-back grants:
  - Reads on consecutive cycles give consecutive rvalid pulses, in the same order as the grants.
  - A read followed by a write: the read's rvalid appears in the write cycle with the correct data, because o_data was registered on the read edge.
- Simultaneous r0_req and r1_req in ST_NORMAL: requester 0 wins, and requester 1's counter increments.

Decomposition:
- Package bram_arb_pkg holds:
  - state encoding ST_NORMAL=1'b0, ST_FORCE=1'b1;
  - requester indices REQ_CPU=0, REQ_DBG=1;
  - counter width STARVE_W=8.
- One sub-module, bram_starve_counter: the saturating counter with clear, increment, STARVE_LIMIT compare, and the force output.
- Grant mux and rvalid registers stay in bram_arbiter.

Test Plan:
- Reset mid-read: grant r0 read of addr 0x10, assert rst before the next edge -> r0_rvalid stays 0; after release, all outputs are 0 and state is ST_NORMAL.
- Requester 0 only: write 0xDEADBEEF at 0x05, then read 0x05 -> r0_gnt=1 both cycles, bram_we 1 then 0, r0_rvalid one cycle after the read with rdata=0xDEADBEEF.
- Requester 1 only: read 0x20 preloaded with 0x12345678 -> r1_gnt the same cycle, r1_rvalid the next cycle with rdata=0x12345678, r0_rvalid stays 0.
- Contention, STARVE_LIMIT=4, r0_req and r1_req held high continuously:
  - r0 is granted in cycles 0..3;
  - r1 is granted in cycle 4;
  - r0 is granted in cycles 5..8;
  - r1 is granted in cycle 9;
  - gnt is never high for both requesters in the same cycle.
- Forced state abandoned: reach ST_FORCE, then drop r1_req the same cycle -> r0 is granted, and the state and counter return to ST_NORMAL/0 on the next edge.
- Pipelined reads: r0 reads 0x01, 0x02, 0x03 on consecutive cycles, then writes 0x04 -> three consecutive r0_rvalid pulses with the matching data, the last one coinciding with the write cycle.
